// File: rtl/razor_recovery_controller.sv
// razor_recovery_controller
//   Sequences pipeline recovery when a transition detector flags a late
//   transition. The sequence is IDLE -> STALL -> FLUSH -> REPLAY -> IDLE.
//   The controller also reports the offending stage and keeps a saturating
//   error-event count.
//   Every output is a Moore decode of the registered state, err_stage and
//   err_count.
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high
//   det_en     in   error monitoring enable; flags are ignored when 0
//   err_flag   in   transition-detector outputs, bit i = stage i
//   stall      out  freeze pipeline registers (STALL and FLUSH)
//   flush      out  squash in-flight instructions (FLUSH)
//   det_clear  out  reset all transition detectors (FLUSH)
//   replay     out  re-issue window from err_stage (REPLAY)
//   err_stage  out  stage index latched at detection
//   err_count  out  detected error events, saturating
//   busy       out  high whenever the state is not IDLE
module razor_recovery_controller #(
  parameter int unsigned NUM_STAGES    = 4,
  parameter int unsigned IDX_WIDTH     = 2,
  parameter int unsigned STALL_CYCLES  = 1,
  parameter int unsigned REPLAY_CYCLES = 2,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  det_en,
  input  logic [NUM_STAGES-1:0] err_flag,
  output logic                  stall,
  output logic                  flush,
  output logic                  det_clear,
  output logic                  replay,
  output logic [IDX_WIDTH-1:0]  err_stage,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic                  busy
);

  localparam int unsigned MAXC = (STALL_CYCLES > REPLAY_CYCLES) ? STALL_CYCLES : REPLAY_CYCLES;
  localparam int unsigned TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STALL  = 2'd1,
    S_FLUSH  = 2'd2,
    S_REPLAY = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [IDX_WIDTH-1:0]   err_stage_q, err_stage_d;
  logic [CNT_WIDTH-1:0]   err_count_q, err_count_d;

  logic                   detect;
  logic [IDX_WIDTH-1:0]   det_idx;
  logic                   found;

  // Lowest-index set flag wins; stage 0 has the highest priority.
  always_comb begin
    det_idx = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      if (err_flag[i] && !found) begin
        det_idx = IDX_WIDTH'(i);
        found   = 1'b1;
      end
    end
  end

  assign detect = det_en & (|err_flag);

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    err_stage_d = err_stage_q;
    err_count_d = err_count_q;
    unique case (state_q)
      S_IDLE: begin
        if (detect) begin
          state_d     = S_STALL;
          timer_d     = '0;
          err_stage_d = det_idx;
          if (err_count_q != '1) begin
            err_count_d = err_count_q + 1'b1;
          end
        end
      end
      S_STALL: begin
        if (timer_q == TW'(STALL_CYCLES - 1)) begin
          state_d = S_FLUSH;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_FLUSH: begin
        state_d = S_REPLAY;
        timer_d = '0;
      end
      S_REPLAY: begin
        if (timer_q == TW'(REPLAY_CYCLES - 1)) begin
          state_d = S_IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      err_stage_q <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      err_stage_q <= err_stage_d;
      err_count_q <= err_count_d;
    end
  end

  always_comb begin
    stall     = (state_q == S_STALL) || (state_q == S_FLUSH);
    flush     = (state_q == S_FLUSH);
    det_clear = (state_q == S_FLUSH);
    replay    = (state_q == S_REPLAY);
    busy      = (state_q != S_IDLE);
  end

  assign err_stage = err_stage_q;
  assign err_count = err_count_q;

endmodule
